// File: rtl/imem_pkg.sv
// Shared types and the default LEGv8 program image for the instruction memory.
package imem_pkg;

  localparam int unsigned DEFAULT_DEPTH = 64;
  localparam int unsigned PROG_LEN      = 47;
  localparam int unsigned PW            = $clog2(PROG_LEN);

  // Fetch FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Default program, word-indexed (byte address = index * 4)
  localparam logic [31:0] DEFAULT_PROG [PROG_LEN] = '{
    32'hf8000001, 32'hf8008002, 32'hf8010003, 32'h8b050083, 32'hf8018004,
    32'hcb050083, 32'hf8020005, 32'h8a050083, 32'hf8028006, 32'haa050083,
    32'hf8030007, 32'hb4000040, 32'hf8038008, 32'h8b1f03e5, 32'h91000421,
    32'hf84003e9, 32'hf84083ea, 32'hf84103eb, 32'hf84183ec, 32'hf84203ed,
    32'hcb0a0129, 32'hb5000049, 32'h8b0b016c, 32'h8b0d01ac, 32'hf80203ec,
    32'hf80283ed, 32'hd1000421, 32'hb5ffff21, 32'h17fffff0, 32'h910003e0,
    32'h91000400, 32'hd37ff800, 32'hd341fc00, 32'h8b000000, 32'hcb000000,
    32'hf80303e0, 32'hf84303e1, 32'heb01001f, 32'h54000040, 32'hf80383e1,
    32'h14000002, 32'hf80383e0, 32'hd2800020, 32'hf80403e0, 32'haa1f03e0,
    32'h14000001, 32'hb400001f
  };

  // Program word at a word index; zero past the end of the program
  function automatic logic [31:0] prog_word(input int unsigned idx);
    if (idx < PROG_LEN) return DEFAULT_PROG[PW'(idx)];
    return 32'h0;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: synchronous read register plus optional load port.
// Build option: IMEM_LOAD_EN enables run-time writes; otherwise a fixed ROM.
module imem_array
  import imem_pkg::*;
#(
  parameter  int unsigned N     = 32,
  parameter  int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_rd_en,
  input  logic          i_rd_clr,
  input  logic [AW-1:0] i_rd_addr,
  output logic [N-1:0]  o_rd_data,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [N-1:0]  i_wdata
);

  logic [N-1:0] w_rword;
  logic [N-1:0] r_rdata;

`ifdef IMEM_LOAD_EN
  logic [N-1:0] w_words [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic [N-1:0] r_word = N'(prog_word(g));

    // Load write; a write coinciding with reset is dropped, reset keeps contents
    always_ff @(posedge i_clk) begin
      if (i_we && !i_rst && (i_waddr == AW'(g))) r_word <= i_wdata;
    end

    assign w_words[g] = r_word;
  end

  assign w_rword = w_words[i_rd_addr];
`else
  logic w_unused_ld;
  assign w_unused_ld = ^{i_we, i_waddr, i_wdata};
  assign w_rword     = N'(prog_word(32'(i_rd_addr)));
`endif

  // Synchronous read; error fetches load zero without reading the array
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_rd_en) begin
      r_rdata <= i_rd_clr ? '0 : w_rword;
    end
  end

  assign o_rd_data = r_rdata;

endmodule

// File: rtl/imem_ws.sv
// Instruction memory with valid/ready fetch handshake and WAIT wait states.
// Build option: IMEM_LOAD_EN enables the ld_* load port.
module imem_ws
  import imem_pkg::*;
#(
  parameter  int unsigned N     = 32,
  parameter  int unsigned DEPTH = DEFAULT_DEPTH,
  parameter  int unsigned WAIT  = 0,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [63:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  rsp_data,
  output logic          rsp_err,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [N-1:0]  ld_data
);

  localparam int unsigned CW = 4;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [AW-1:0] r_idx, w_idx_nxt;
  logic          r_err, w_err_nxt;
  logic          r_rsp_valid;
  logic          r_rsp_err;
  logic          w_accept;
  logic          w_rd_en;
  logic          w_rd_clr;
  logic [AW-1:0] w_rd_idx;
  logic [AW-1:0] w_req_idx;
  logic          w_req_err;

  assign w_req_idx = req_addr[AW+1:2];
  assign w_req_err = (req_addr[1:0] != 2'b00) || (req_addr[63:2] >= 62'(DEPTH));

  // Next state, handshake and read-port control
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_err_nxt   = r_err;
    w_rd_en     = 1'b0;
    w_rd_idx    = r_idx;
    w_rd_clr    = r_err;
    req_ready   = (r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready);
    w_accept    = req_valid && req_ready;

    case (r_state)
      ST_IDLE: ;
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = ST_RESP;
          w_rd_en     = 1'b1;
        end
      end
      ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase

    // A new accept overrides the RESP exit (back-to-back fetch)
    if (w_accept) begin
      w_idx_nxt = w_req_idx;
      w_err_nxt = w_req_err;
      w_cnt_nxt = CW'(WAIT);
      if (WAIT == 0) begin
        w_state_nxt = ST_RESP;
        w_rd_en     = 1'b1;
        w_rd_idx    = w_req_idx;
        w_rd_clr    = w_req_err;
      end else begin
        w_state_nxt = ST_WAIT;
      end
    end
  end

  // State, counter, captured request and response flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_err       <= w_err_nxt;
      r_rsp_valid <= (w_state_nxt == ST_RESP);
      if (w_rd_en) r_rsp_err <= w_rd_clr;
    end
  end

  imem_array #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_array (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_rd_en   (w_rd_en),
    .i_rd_clr  (w_rd_clr),
    .i_rd_addr (w_rd_idx),
    .o_rd_data (rsp_data),
    .i_we      (ld_en),
    .i_waddr   (ld_addr),
    .i_wdata   (ld_data)
  );

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_imem_ws.sv
// Bench for imem_ws: three instances with WAIT = 0, 3, 4 sharing clock, reset and load port.
module tb_imem_ws;

  localparam int unsigned NI = 3;
`ifdef IMEM_LOAD_EN
  localparam bit LOAD = 1'b1;
`else
  localparam bit LOAD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [NI];
  logic [63:0] req_addr  [NI];
  logic        rsp_ready [NI];
  logic        req_ready [NI];
  logic        rsp_valid [NI];
  logic [31:0] rsp_data  [NI];
  logic        rsp_err   [NI];
  logic        ld_en;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imem_ws #(.N(32), .DEPTH(64), .WAIT(0)) u_w0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  imem_ws #(.N(32), .DEPTH(64), .WAIT(3)) u_w3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  imem_ws #(.N(32), .DEPTH(64), .WAIT(4)) u_w4 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_addr(req_addr[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_data(rsp_data[2]), .rsp_err(rsp_err[2]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One fetch from IDLE: returns data, err, cycles to rsp_valid and cycles with req_ready low
  task automatic fetch(input int k, input logic [63:0] addr,
                       output logic [31:0] data, output logic err,
                       output int lat, output int rdy_low);
    @(posedge clk); #1;
    req_valid[k] = 1'b1; req_addr[k] = addr; rsp_ready[k] = 1'b0;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    lat = 0; rdy_low = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!rsp_valid[k] && !req_ready[k]) rdy_low++;
    end while (!rsp_valid[k] && lat < 40);
    data = rsp_data[k];
    err  = rsp_err[k];
    @(posedge clk); #1;
    rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[k] = 1'b0;
  endtask

  // Wait (bounded) for rsp_valid on instance k; returns negedges counted
  task automatic wait_rsp(input int k, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[k] && n < 40);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat, rl, n;

    reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    for (int k = 0; k < NI; k++) begin
      req_valid[k] = 1'b0; req_addr[k] = '0; rsp_ready[k] = 1'b0;
    end

    vecs[0]  = '{64'd0,                  32'hf8000001, 1'b0};
    vecs[1]  = '{64'd4,                  32'hf8008002, 1'b0};
    vecs[2]  = '{64'd12,                 32'h8b050083, 1'b0};
    vecs[3]  = '{64'd184,                32'hb400001f, 1'b0};
    vecs[4]  = '{64'd188,                32'h00000000, 1'b0};
    vecs[5]  = '{64'd252,                32'h00000000, 1'b0};
    vecs[6]  = '{64'd6,                  32'h00000000, 1'b1};
    vecs[7]  = '{64'd2,                  32'h00000000, 1'b1};
    vecs[8]  = '{64'd256,                32'h00000000, 1'b1};
    vecs[9]  = '{64'h0000_0001_0000_0000, 32'h00000000, 1'b1};
    vecs[10] = '{64'hffff_ffff_ffff_fffc, 32'h00000000, 1'b1};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state of every instance
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_valid%0d", k), 64'(rsp_valid[k]), 64'd0);
      chk($sformatf("rst_ready%0d", k), 64'(req_ready[k]), 64'd1);
      chk($sformatf("rst_data%0d", k),  64'(rsp_data[k]),  64'd0);
      chk($sformatf("rst_err%0d", k),   64'(rsp_err[k]),   64'd0);
    end

    // Table of single fetches with WAIT=0
    for (int i = 0; i < 11; i++) begin
      fetch(0, vecs[i].addr, d, e, lat, rl);
      chk($sformatf("vec%0d_data", i), 64'(d),   64'(vecs[i].data));
      chk($sformatf("vec%0d_err", i),  64'(e),   64'(vecs[i].err));
      chk($sformatf("vec%0d_lat", i),  64'(lat), 64'd1);
    end

    // Wait-state latency and req_ready low during WAIT
    fetch(1, 64'd12, d, e, lat, rl);
    chk("w3_data", 64'(d), 64'h8b050083);
    chk("w3_err",  64'(e), 64'd0);
    chk("w3_lat",  64'(lat), 64'd4);
    chk("w3_rdylow", 64'(rl), 64'd3);
    fetch(1, 64'd6, d, e, lat, rl);
    chk("w3_mis_err", 64'(e), 64'd1);
    chk("w3_mis_data", 64'(d), 64'd0);
    chk("w3_mis_lat", 64'(lat), 64'd4);
    fetch(2, 64'd4, d, e, lat, rl);
    chk("w4_data", 64'(d), 64'hf8008002);
    chk("w4_lat",  64'(lat), 64'd5);
    chk("w4_rdylow", 64'(rl), 64'd4);

    // Response held while rsp_ready low, then back-to-back accept
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_addr[0] = 64'd8; rsp_ready[0] = 1'b0;
    @(posedge clk); #1;
    req_addr[0] = 64'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_valid", i), 64'(rsp_valid[0]), 64'd1);
      chk($sformatf("hold%0d_data", i),  64'(rsp_data[0]),  64'hf8010003);
      chk($sformatf("hold%0d_ready", i), 64'(req_ready[0]), 64'd0);
      @(posedge clk); #1;
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("b2b_ready", 64'(req_ready[0]), 64'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("b2b_valid", 64'(rsp_valid[0]), 64'd1);
    chk("b2b_data",  64'(rsp_data[0]),  64'hf8008002);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_drop_valid", 64'(rsp_valid[0]), 64'd0);
    chk("b2b_idle_ready", 64'(req_ready[0]), 64'd1);
    rsp_ready[0] = 1'b0;

    // Throughput with rsp_ready held high, WAIT=3: one fetch per 4 cycles
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_addr[1] = 64'd0; rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    req_addr[1] = 64'd4;
    wait_rsp(1, n);
    chk("tp_first_lat",  64'(n), 64'd4);
    chk("tp_first_data", 64'(rsp_data[1]), 64'hf8000001);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_rsp(1, n);
    chk("tp_period",      64'(n), 64'd4);
    chk("tp_second_data", 64'(rsp_data[1]), 64'hf8008002);
    @(posedge clk); #1;
    rsp_ready[1] = 1'b0;

    // Reset during WAIT abandons the fetch; a load on the reset edge is dropped
    @(posedge clk); #1;
    req_valid[2] = 1'b1; req_addr[2] = 64'd0;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; ld_en = 1'b1; ld_addr = 6'd3; ld_data = 32'h11111111;
    @(posedge clk); #1;
    reset = 1'b0; ld_en = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid[2]) n++;
    end
    chk("rstw_no_rsp", 64'(n), 64'd0);
    chk("rstw_ready",  64'(req_ready[2]), 64'd1);
    chk("rstw_data",   64'(rsp_data[2]),  64'd0);
    fetch(0, 64'd12, d, e, lat, rl);
    chk("rstw_ld_dropped", 64'(d), 64'h8b050083);

    // Load port write, then fetch the written word
    @(posedge clk); #1;
    ld_en = 1'b1; ld_addr = 6'd5; ld_data = 32'hdeadbeef;
    @(posedge clk); #1;
    ld_en = 1'b0;
    fetch(0, 64'd20, d, e, lat, rl);
    chk("ld_word5", 64'(d), LOAD ? 64'hdeadbeef : 64'hcb050083);

    // Write on the RESP-entry edge returns the old word
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_addr[0] = 64'd4;
    ld_en = 1'b1; ld_addr = 6'd1; ld_data = 32'h12345678;
    @(posedge clk); #1;
    req_valid[0] = 1'b0; ld_en = 1'b0;
    @(negedge clk);
    chk("rbw_valid", 64'(rsp_valid[0]), 64'd1);
    chk("rbw_old",   64'(rsp_data[0]),  64'hf8008002);
    @(posedge clk); #1;
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    fetch(0, 64'd4, d, e, lat, rl);
    chk("rbw_new", 64'(d), LOAD ? 64'h12345678 : 64'hf8008002);

    // Write during WAIT to the pending word is seen in the response
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_addr[1] = 64'd8;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    ld_en = 1'b1; ld_addr = 6'd2; ld_data = 32'hcafef00d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    wait_rsp(1, n);
    chk("wwait_valid", 64'(rsp_valid[1]), 64'd1);
    chk("wwait_data",  64'(rsp_data[1]), LOAD ? 64'hcafef00d : 64'hf8010003);
    @(posedge clk); #1;
    rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[1] = 1'b0;

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_ws.md
# imem_ws

Parametrised instruction memory for the LEGv8 core: a word array with a synchronous read and a valid/ready fetch handshake. It takes a 64-bit byte PC and a configurable number of wait states, and flags misaligned or out-of-range fetches. An optional load port writes program words at run time. It replaces the combinational ROM in the fetch stage, so the core can be exercised against a slow instruction memory.

## Interface
- N, 32, instruction width in bits
- DEPTH, 64, number of words; any value ≥ 2
- WAIT, 0, extra wait-state cycles per fetch (0..15)
- AW, $clog2(DEPTH), word-index width (derived, not overridden)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  fetch request present
- req_ready  out  1  request accepted this cycle when high together with req_valid
- req_addr  in  64  byte address (PC)
- rsp_valid  out  1  response holds rsp_data/rsp_err
- rsp_ready  in  1  consumer takes the response
- rsp_data  out  N  fetched word; 0 on error
- rsp_err  out  1  misaligned or out-of-range fetch
- ld_en  in  1  load-port write strobe
- ld_addr  in  AW  load word index
- ld_data  in  N  load data

## Operation
- The FSM has three states: IDLE, WAIT, RESP.
- req_ready = (state==IDLE) || (state==RESP && rsp_ready).
- Accept on req_valid && req_ready:
  - capture the word index req_addr[AW+1:2];
  - set err = (req_addr[1:0]!=0) || (req_addr[63:2] >= DEPTH);
  - load cnt = WAIT.
- After accept: if WAIT==0 go to RESP; otherwise go to WAIT.
- In WAIT, cnt decrements each cycle. At cnt==1 go to RESP.
- On entry to RESP, rsp_data/rsp_err are registered: rsp_data is the array word at the captured index, or 0 if err.
- In RESP, rsp_valid=1 and rsp_data/rsp_err are held stable until rsp_ready.
- On rsp_ready in RESP:
  - if a new request is accepted the same cycle, continue with it (back-to-back);
  - otherwise return to IDLE and drop rsp_valid.
- Load port: ld_en writes ld_data to word ld_addr on the clock edge. This happens in any state and regardless of the handshake.
  - ld_addr ≥ DEPTH is ignored.
  - A write and a read of the same word on the same edge is read-before-write: the response returns the old word.
  - A write during WAIT to the pending word does affect the response, because the read happens on the RESP-entry edge.
- Error responses have the same latency as normal ones. The array is not accessed.

## Timing
- Reset values: state=IDLE, cnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, req_ready=1.
- Reset does not clear the array.
- Latency: rsp_valid rises WAIT+1 cycles after the accept edge.
- Throughput with rsp_ready held high: one fetch per WAIT+1 cycles.
- req_ready is low throughout WAIT.
- Reset asserted mid-fetch: the transaction is abandoned and no response is issued. A load write on that same edge is discarded.
- req_valid may drop without being accepted; no state change results.

## Configuration
- IMEM_LOAD_EN defined: the load port writes as described.
- IMEM_LOAD_EN undefined:
  - ld_en, ld_addr and ld_data are present but ignored;
  - the array is read-only and holds the package default program.
- The array is initialised from the package program in both builds. Words beyond the program are 0.

## Structure
- imem_pkg holds:
  - the state enum type (IDLE, WAIT, RESP);
  - the default program as a constant array of 47 words, with word 0 = 32'hf8000001 and word 46 = 32'hb400001f;
  - localparam DEFAULT_DEPTH = 64.
- Sub-module imem_array holds the storage: parametrised N/DEPTH, a synchronous read port, and a write port gated by IMEM_LOAD_EN.
- imem_ws holds the FSM, counter, address checks and response registers.

## Test plan
- Reset, then req_addr=0 with WAIT=0 → rsp_valid one cycle after accept; rsp_data=32'hf8000001, rsp_err=0.
- WAIT=3, req_addr=12 → rsp_valid exactly 4 cycles after accept; rsp_data=32'h8b050083; req_ready low for 3 cycles.
- req_addr=6 (misaligned) → rsp_err=1, rsp_data=0. With DEPTH=64, req_addr=256 → rsp_err=1.
- rsp_ready low for 5 cycles in RESP → rsp_data stable and no new accept. Then rsp_ready=1 with req_valid=1, req_addr=4 → back-to-back accept; the next response is 32'hf8008002.
- IMEM_LOAD_EN defined: ld_en with ld_addr=5, ld_data=32'hdeadbeef, then fetch req_addr=20 → 32'hdeadbeef. Load to the same word on the RESP-entry edge → old word returned.
- Reset asserted during WAIT (WAIT=4) → no rsp_valid afterwards, state IDLE, req_ready=1.
